// File: rtl/round_ctrl_pkg.sv
// Shared encodings for the round sequencer: state codes, winner codes and
// the widths the HUD sees. Imported by the interface, the top and the bench.
package round_pkg;

    localparam int TIMER_W = 7;
    localparam int WINS_W  = 2;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_ROUND_INIT = 3'd1;
    localparam logic [2:0] ST_COUNTDOWN  = 3'd2;
    localparam logic [2:0] ST_FIGHT      = 3'd3;
    localparam logic [2:0] ST_KO         = 3'd4;
    localparam logic [2:0] ST_MATCH_OVER = 3'd5;

    typedef enum logic [2:0] {
        IDLE       = ST_IDLE,
        ROUND_INIT = ST_ROUND_INIT,
        COUNTDOWN  = ST_COUNTDOWN,
        FIGHT      = ST_FIGHT,
        KO         = ST_KO,
        MATCH_OVER = ST_MATCH_OVER
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;
    localparam logic [1:0] WIN_DRAW = 2'd3;

    // Win counters stick at their maximum instead of wrapping.
    function automatic logic [WINS_W-1:0] sat_inc(input logic [WINS_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/round_ctrl_if.sv
// Game-side bus of the round sequencer: frame tick, start button and HP in,
// HUD/movement control out. master = game logic, slave = round_ctrl.
interface round_ctrl_if #(
    parameter int HP_W = 7
);
    import round_pkg::*;

    logic                frame_tick;
    logic                start_btn;
    logic [HP_W-1:0]     p1_hp;
    logic [HP_W-1:0]     p2_hp;
    logic                move_enable;
    logic                round_reset;
    logic [2:0]          state;
    logic [TIMER_W-1:0]  timer_sec;
    logic [WINS_W-1:0]   p1_wins;
    logic [WINS_W-1:0]   p2_wins;
    logic [1:0]          round_winner;
    logic                match_over;

    modport master (
        output frame_tick, start_btn, p1_hp, p2_hp,
        input  move_enable, round_reset, state, timer_sec,
               p1_wins, p2_wins, round_winner, match_over
    );

    modport slave (
        input  frame_tick, start_btn, p1_hp, p2_hp,
        output move_enable, round_reset, state, timer_sec,
               p1_wins, p2_wins, round_winner, match_over
    );

endinterface

// File: rtl/round_ctrl_frame_sec_timer.sv
// Loadable seconds/frames down-counter. Each enabled tick consumes one frame;
// when the frame count wraps, one second is taken off. expire flags the tick
// that takes the seconds count from 1 to 0.
module frame_sec_timer #(
    parameter int FPS   = 60,
    parameter int SEC_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [SEC_W-1:0] load_sec,
    input  logic             tick,
    output logic [SEC_W-1:0] sec,
    output logic             expire
);

    localparam int FRM_W = (FPS > 1) ? $clog2(FPS) : 1;
    localparam logic [FRM_W-1:0] FRM_MAX = FRM_W'(FPS - 1);

    logic [FRM_W-1:0] frm;

    // Depends only on tick and the counter flops, so a load driven from it
    // does not form a loop.
    assign expire = tick && (frm == '0) && (sec == SEC_W'(1));

    // Load wins over tick; seconds never wrap below zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            sec <= '0;
            frm <= '0;
        end else if (load) begin
            sec <= load_sec;
            frm <= FRM_MAX;
        end else if (tick) begin
            if (frm == '0) begin
                frm <= FRM_MAX;
                if (sec != '0) sec <= sec - 1'b1;
            end else begin
                frm <= frm - 1'b1;
            end
        end
    end

endmodule

// File: rtl/round_ctrl.sv
// Match/round sequencer for the fighter game. Counts frames via frame_tick,
// gates player movement, pulses round_reset and keeps round/match score.
// Build option: ROUND_CTRL_TIMEOUT_EN enables the fight round timer and the
// timeout decision; without it a round ends only on HP=0.
module round_ctrl
    import round_pkg::*;
#(
    parameter int FPS           = 60,
    parameter int COUNTDOWN_SEC = 3,
    parameter int ROUND_SEC     = 99,
    parameter int KO_HOLD_SEC   = 2,
    parameter int WINS_TO_MATCH = 2,
    parameter int HP_W          = 7
) (
    input  logic         clk,
    input  logic         reset,
    round_ctrl_if.slave  bus
);

    localparam int HOLD_FRAMES = KO_HOLD_SEC * FPS;
    localparam int HOLD_W      = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_FRAMES);
    localparam logic [WINS_W-1:0]  WINS_NEED  = WINS_W'(WINS_TO_MATCH);
    localparam logic [TIMER_W-1:0] CD_LOAD    = TIMER_W'(COUNTDOWN_SEC);
    localparam logic [TIMER_W-1:0] FIGHT_LOAD = TIMER_W'(ROUND_SEC);

    state_t              st;
    logic                start_prev;
    logic                start_edge;
    logic                move_en_q;
    logic                round_reset_q;
    logic                match_over_q;
    logic [WINS_W-1:0]   p1_wins_q;
    logic [WINS_W-1:0]   p2_wins_q;
    logic [1:0]          winner_q;
    logic [HOLD_W-1:0]   hold;
    logic [HP_W-1:0]     p1_hp;
    logic [HP_W-1:0]     p2_hp;

    logic                tmr_load;
    logic                tmr_tick;
    logic                tmr_expire;
    logic [TIMER_W-1:0]  tmr_load_sec;
    logic [TIMER_W-1:0]  timer_sec;

    logic                end_hit;
    logic [1:0]          end_code;

    assign p1_hp      = bus.p1_hp;
    assign p2_hp      = bus.p2_hp;
    assign start_edge = bus.start_btn && !start_prev;

    // Countdown is loaded in ROUND_INIT, the fight time on the last countdown tick.
    always_comb begin
        tmr_load     = (st == ROUND_INIT) || ((st == COUNTDOWN) && tmr_expire);
        tmr_load_sec = (st == ROUND_INIT) ? CD_LOAD : FIGHT_LOAD;
`ifdef ROUND_CTRL_TIMEOUT_EN
        tmr_tick     = bus.frame_tick && ((st == COUNTDOWN) || (st == FIGHT));
`else
        tmr_tick     = bus.frame_tick && (st == COUNTDOWN);
`endif
    end

    frame_sec_timer #(
        .FPS   (FPS),
        .SEC_W (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_sec (tmr_load_sec),
        .tick     (tmr_tick),
        .sec      (timer_sec),
        .expire   (tmr_expire)
    );

    // Round end decision, evaluated only on frame ticks; KO outranks timeout.
    always_comb begin
        end_hit  = 1'b0;
        end_code = WIN_NONE;
        if ((st == FIGHT) && bus.frame_tick) begin
            if ((p1_hp == '0) && (p2_hp == '0)) begin
                end_hit  = 1'b1;
                end_code = WIN_DRAW;
            end else if (p1_hp == '0) begin
                end_hit  = 1'b1;
                end_code = WIN_P2;
            end else if (p2_hp == '0) begin
                end_hit  = 1'b1;
                end_code = WIN_P1;
            end
`ifdef ROUND_CTRL_TIMEOUT_EN
            else if (tmr_expire) begin
                end_hit  = 1'b1;
                end_code = (p1_hp > p2_hp) ? WIN_P1 :
                           (p2_hp > p1_hp) ? WIN_P2 : WIN_DRAW;
            end
`endif
        end
    end

    // Sequencer FSM with registered control and score outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            st            <= IDLE;
            start_prev    <= 1'b0;
            move_en_q     <= 1'b0;
            round_reset_q <= 1'b0;
            match_over_q  <= 1'b0;
            p1_wins_q     <= '0;
            p2_wins_q     <= '0;
            winner_q      <= WIN_NONE;
            hold          <= '0;
        end else begin
            start_prev    <= bus.start_btn;
            round_reset_q <= 1'b0;
            case (st)
                IDLE: begin
                    p1_wins_q <= '0;
                    p2_wins_q <= '0;
                    winner_q  <= WIN_NONE;
                    if (start_edge) begin
                        st            <= ROUND_INIT;
                        round_reset_q <= 1'b1;
                    end
                end
                ROUND_INIT: st <= COUNTDOWN;
                COUNTDOWN: begin
                    if (tmr_expire) begin
                        st        <= FIGHT;
                        move_en_q <= 1'b1;
                    end
                end
                FIGHT: begin
                    if (end_hit) begin
                        st        <= KO;
                        move_en_q <= 1'b0;
                        winner_q  <= end_code;
                        hold      <= HOLD_LOAD;
                        if (end_code == WIN_P1) p1_wins_q <= sat_inc(p1_wins_q);
                        if (end_code == WIN_P2) p2_wins_q <= sat_inc(p2_wins_q);
                    end
                end
                KO: begin
                    if (bus.frame_tick) begin
                        if (hold <= HOLD_W'(1)) begin
                            if ((p1_wins_q >= WINS_NEED) || (p2_wins_q >= WINS_NEED)) begin
                                st           <= MATCH_OVER;
                                match_over_q <= 1'b1;
                            end else begin
                                st            <= ROUND_INIT;
                                round_reset_q <= 1'b1;
                            end
                        end else begin
                            hold <= hold - 1'b1;
                        end
                    end
                end
                MATCH_OVER: begin
                    if (start_edge) begin
                        st            <= ROUND_INIT;
                        round_reset_q <= 1'b1;
                        match_over_q  <= 1'b0;
                        p1_wins_q     <= '0;
                        p2_wins_q     <= '0;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign bus.state        = st;
    assign bus.move_enable  = move_en_q;
    assign bus.round_reset  = round_reset_q;
    assign bus.timer_sec    = timer_sec;
    assign bus.p1_wins      = p1_wins_q;
    assign bus.p2_wins      = p2_wins_q;
    assign bus.round_winner = winner_q;
    assign bus.match_over   = match_over_q;

endmodule

// File: tb/tb_round_ctrl.sv
// Bench for round_ctrl: scenario tasks in sequence, round results predicted
// by a small score model and queued, then popped when the round ends.
module tb_round_ctrl;
    import round_pkg::*;

    localparam int FPS      = 60;
    localparam int CD_SEC   = 3;
    localparam int RND_SEC  = 99;
    localparam int HOLD_SEC = 2;
    localparam int WINS     = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    round_ctrl_if #(.HP_W(7)) bus();

    round_ctrl #(
        .FPS(FPS), .COUNTDOWN_SEC(CD_SEC), .ROUND_SEC(RND_SEC),
        .KO_HOLD_SEC(HOLD_SEC), .WINS_TO_MATCH(WINS), .HP_W(7)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [1:0] w;
        logic [1:0] p1;
        logic [1:0] p2;
    } res_t;

    res_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [1:0] m1 = 2'd0;
    logic [1:0] m2 = 2'd0;

    // One frame tick; returns at the negedge after the sampling posedge.
    task automatic tick();
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            @(negedge clk);
        end
    endtask

    function automatic logic [1:0] ref_winner(input int a, input int b, input bit to);
        if (a == 0 && b == 0) return WIN_DRAW;
        if (a == 0) return WIN_P2;
        if (b == 0) return WIN_P1;
        if (to) return (a > b) ? WIN_P1 : (b > a) ? WIN_P2 : WIN_DRAW;
        return WIN_NONE;
    endfunction

    // Score model: predict the outcome and queue it.
    task automatic expect_end(input int a, input int b, input bit to);
        logic [1:0] w;
        w = ref_winner(a, b, to);
        if (w == WIN_P1 && m1 != 2'd3) m1 = m1 + 2'd1;
        if (w == WIN_P2 && m2 != 2'd3) m2 = m2 + 2'd1;
        sb.push_back({w, m1, m2});
    endtask

    task automatic goto_fight();
        if (bus.state == ST_ROUND_INIT) @(negedge clk);
        if (bus.state == ST_COUNTDOWN) ticks(CD_SEC * FPS);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.frame_tick = 1'b0; bus.start_btn = 1'b0;
        bus.p1_hp = 7'd100; bus.p2_hp = 7'd100;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus.state, bus.move_enable, bus.round_reset, bus.timer_sec, bus.p1_wins,
             bus.p2_wins, bus.round_winner, bus.match_over} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d me=%0d rr=%0d t=%0d w=%0d/%0d rw=%0d mo=%0d, want all 0",
                     bus.state, bus.move_enable, bus.round_reset, bus.timer_sec,
                     bus.p1_wins, bus.p2_wins, bus.round_winner, bus.match_over);
        end
    endtask

    task automatic test_countdown();
        // start edge together with a frame tick: the tick must be ignored
        bus.start_btn = 1'b1; bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.start_btn = 1'b0; bus.frame_tick = 1'b0;
        n_tests++;
        if (bus.state !== ST_ROUND_INIT || bus.round_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL start_init: state=%0d rr=%0d, want %0d/1", bus.state, bus.round_reset, ST_ROUND_INIT);
        end
        @(negedge clk);
        n_tests++;
        if (bus.state !== ST_COUNTDOWN || bus.round_reset !== 1'b0 || bus.timer_sec !== 7'(CD_SEC)) begin
            n_fail++;
            $display("FAIL cd_entry: state=%0d rr=%0d t=%0d, want %0d/0/%0d",
                     bus.state, bus.round_reset, bus.timer_sec, ST_COUNTDOWN, CD_SEC);
        end
        ticks(FPS);
        n_tests++;
        if (bus.timer_sec !== 7'(CD_SEC - 1)) begin
            n_fail++;
            $display("FAIL cd_one_sec: timer=%0d, want %0d", bus.timer_sec, CD_SEC - 1);
        end
        ticks((CD_SEC - 1) * FPS - 1);
        n_tests++;
        if (bus.state !== ST_COUNTDOWN || bus.timer_sec !== 7'd1 || bus.move_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL cd_last: state=%0d t=%0d me=%0d, want %0d/1/0",
                     bus.state, bus.timer_sec, bus.move_enable, ST_COUNTDOWN);
        end
        tick();
        n_tests++;
        if (bus.state !== ST_FIGHT || bus.move_enable !== 1'b1 || bus.timer_sec !== 7'(RND_SEC)) begin
            n_fail++;
            $display("FAIL fight_entry: state=%0d me=%0d t=%0d, want %0d/1/%0d",
                     bus.state, bus.move_enable, bus.timer_sec, ST_FIGHT, RND_SEC);
        end
        @(negedge clk);
    endtask

    task automatic test_ko_p1();
        res_t e;
        bus.p1_hp = 7'd50; bus.p2_hp = 7'd60;
        ticks(10);
        bus.p2_hp = 7'd0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.state !== ST_FIGHT || bus.move_enable !== 1'b1 || bus.round_winner !== WIN_NONE) begin
            n_fail++;
            $display("FAIL hp_between_ticks: state=%0d me=%0d rw=%0d, want %0d/1/0",
                     bus.state, bus.move_enable, bus.round_winner, ST_FIGHT);
        end
        expect_end(50, 0, 1'b0);
        tick();
        n_tests++;
        if (bus.state !== ST_KO || bus.move_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL ko_entry_p1: state=%0d me=%0d, want %0d/0", bus.state, bus.move_enable, ST_KO);
        end
        e = sb.pop_front();
        n_tests++;
        if ({bus.round_winner, bus.p1_wins, bus.p2_wins} !== e) begin
            n_fail++;
            $display("FAIL result_p1: rw=%0d w=%0d/%0d, want rw=%0d w=%0d/%0d",
                     bus.round_winner, bus.p1_wins, bus.p2_wins, e.w, e.p1, e.p2);
        end
        bus.p2_hp = 7'd100;
        @(negedge clk);
        ticks(HOLD_SEC * FPS - 1);
        n_tests++;
        if (bus.state !== ST_KO) begin
            n_fail++;
            $display("FAIL ko_hold: state=%0d, want %0d", bus.state, ST_KO);
        end
        tick();
        n_tests++;
        if (bus.state !== ST_ROUND_INIT || bus.round_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL ko_to_init: state=%0d rr=%0d, want %0d/1", bus.state, bus.round_reset, ST_ROUND_INIT);
        end
        @(negedge clk);
        n_tests++;
        if (bus.state !== ST_COUNTDOWN || bus.round_reset !== 1'b0 || bus.timer_sec !== 7'(CD_SEC)) begin
            n_fail++;
            $display("FAIL round2_cd: state=%0d rr=%0d t=%0d, want %0d/0/%0d",
                     bus.state, bus.round_reset, bus.timer_sec, ST_COUNTDOWN, CD_SEC);
        end
    endtask

    task automatic test_draw();
        res_t e;
        goto_fight();
        bus.p1_hp = 7'd0; bus.p2_hp = 7'd0;
        @(negedge clk);
        expect_end(0, 0, 1'b0);
        tick();
        n_tests++;
        if (bus.state !== ST_KO || bus.move_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL ko_entry_draw: state=%0d me=%0d, want %0d/0", bus.state, bus.move_enable, ST_KO);
        end
        e = sb.pop_front();
        n_tests++;
        if ({bus.round_winner, bus.p1_wins, bus.p2_wins} !== e) begin
            n_fail++;
            $display("FAIL result_draw: rw=%0d w=%0d/%0d, want rw=%0d w=%0d/%0d",
                     bus.round_winner, bus.p1_wins, bus.p2_wins, e.w, e.p1, e.p2);
        end
        bus.p1_hp = 7'd100; bus.p2_hp = 7'd100;
        @(negedge clk);
        ticks(HOLD_SEC * FPS - 1);
        tick();
        n_tests++;
        if (bus.state !== ST_ROUND_INIT) begin
            n_fail++;
            $display("FAIL draw_next_round: state=%0d, want %0d", bus.state, ST_ROUND_INIT);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
`ifdef ROUND_CTRL_TIMEOUT_EN
        res_t e;
`endif
        goto_fight();
        bus.p1_hp = 7'd40; bus.p2_hp = 7'd55;
`ifdef ROUND_CTRL_TIMEOUT_EN
        ticks(RND_SEC * FPS - 1);
        n_tests++;
        if (bus.state !== ST_FIGHT || bus.timer_sec !== 7'd1) begin
            n_fail++;
            $display("FAIL timeout_last: state=%0d t=%0d, want %0d/1", bus.state, bus.timer_sec, ST_FIGHT);
        end
        expect_end(40, 55, 1'b1);
        tick();
        n_tests++;
        if (bus.state !== ST_KO || bus.move_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL ko_entry_timeout: state=%0d me=%0d, want %0d/0", bus.state, bus.move_enable, ST_KO);
        end
        e = sb.pop_front();
        n_tests++;
        if ({bus.round_winner, bus.p1_wins, bus.p2_wins} !== e) begin
            n_fail++;
            $display("FAIL result_timeout: rw=%0d w=%0d/%0d, want rw=%0d w=%0d/%0d",
                     bus.round_winner, bus.p1_wins, bus.p2_wins, e.w, e.p1, e.p2);
        end
        @(negedge clk);
        ticks(HOLD_SEC * FPS - 1);
        tick();
        n_tests++;
        if (bus.state !== ST_ROUND_INIT) begin
            n_fail++;
            $display("FAIL timeout_next_round: state=%0d, want %0d", bus.state, ST_ROUND_INIT);
        end
        @(negedge clk);
`else
        ticks(RND_SEC * FPS);
        n_tests++;
        if (bus.state !== ST_FIGHT || bus.timer_sec !== 7'(RND_SEC) || bus.move_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL no_timeout: state=%0d t=%0d me=%0d, want %0d/%0d/1",
                     bus.state, bus.timer_sec, bus.move_enable, ST_FIGHT, RND_SEC);
        end
`endif
    endtask

    task automatic test_match_over();
        res_t e;
        for (int r = 0; r < 3 && int'(m1) < WINS; r++) begin
            bus.p1_hp = 7'd100; bus.p2_hp = 7'd100;
            goto_fight();
            ticks(3);
            bus.p2_hp = 7'd0;
            @(negedge clk);
            expect_end(100, 0, 1'b0);
            tick();
            e = sb.pop_front();
            n_tests++;
            if (bus.state !== ST_KO || {bus.round_winner, bus.p1_wins, bus.p2_wins} !== e) begin
                n_fail++;
                $display("FAIL result_match_r%0d: state=%0d rw=%0d w=%0d/%0d, want state=%0d rw=%0d w=%0d/%0d",
                         r, bus.state, bus.round_winner, bus.p1_wins, bus.p2_wins, ST_KO, e.w, e.p1, e.p2);
            end
            bus.p2_hp = 7'd100;
            @(negedge clk);
            if (int'(m1) < WINS) begin
                ticks(HOLD_SEC * FPS - 1);
                tick();
                @(negedge clk);
            end
        end
        ticks(100);
        bus.start_btn = 1'b1;           // press during KO: ignored, then held
        ticks(HOLD_SEC * FPS - 101);
        n_tests++;
        if (bus.state !== ST_KO) begin
            n_fail++;
            $display("FAIL start_ignored_ko: state=%0d, want %0d", bus.state, ST_KO);
        end
        tick();
        n_tests++;
        if (bus.state !== ST_MATCH_OVER || bus.match_over !== 1'b1 || bus.move_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL match_over: state=%0d mo=%0d me=%0d, want %0d/1/0",
                     bus.state, bus.match_over, bus.move_enable, ST_MATCH_OVER);
        end
        repeat (10) @(negedge clk);
        n_tests++;
        if (bus.state !== ST_MATCH_OVER || bus.p1_wins !== m1) begin
            n_fail++;
            $display("FAIL held_start: state=%0d p1w=%0d, want %0d/%0d", bus.state, bus.p1_wins, ST_MATCH_OVER, m1);
        end
        bus.start_btn = 1'b0;
        repeat (2) @(negedge clk);
        bus.start_btn = 1'b1;
        @(negedge clk);
        bus.start_btn = 1'b0;
        m1 = 2'd0; m2 = 2'd0;
        n_tests++;
        if (bus.state !== ST_ROUND_INIT || bus.round_reset !== 1'b1 || bus.match_over !== 1'b0 ||
            bus.p1_wins !== m1 || bus.p2_wins !== m2) begin
            n_fail++;
            $display("FAIL rematch: state=%0d rr=%0d mo=%0d w=%0d/%0d, want %0d/1/0/0/0",
                     bus.state, bus.round_reset, bus.match_over, bus.p1_wins, bus.p2_wins, ST_ROUND_INIT);
        end
    endtask

    task automatic test_mid_reset();
        bus.p1_hp = 7'd100; bus.p2_hp = 7'd100;
        goto_fight();
        ticks(5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_tests++;
        if ({bus.state, bus.move_enable, bus.round_reset, bus.timer_sec, bus.p1_wins,
             bus.p2_wins, bus.round_winner, bus.match_over} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: state=%0d me=%0d t=%0d w=%0d/%0d rw=%0d, want all 0",
                     bus.state, bus.move_enable, bus.timer_sec, bus.p1_wins, bus.p2_wins, bus.round_winner);
        end
        @(negedge clk);
        bus.start_btn = 1'b1;
        @(negedge clk);
        bus.start_btn = 1'b0;
        n_tests++;
        if (bus.state !== ST_ROUND_INIT || bus.round_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL fresh_start: state=%0d rr=%0d, want %0d/1", bus.state, bus.round_reset, ST_ROUND_INIT);
        end
        @(negedge clk);
        n_tests++;
        if (bus.state !== ST_COUNTDOWN || bus.timer_sec !== 7'(CD_SEC) || bus.p1_wins !== 2'd0) begin
            n_fail++;
            $display("FAIL fresh_cd: state=%0d t=%0d p1w=%0d, want %0d/%0d/0",
                     bus.state, bus.timer_sec, bus.p1_wins, ST_COUNTDOWN, CD_SEC);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_countdown();
        test_ko_p1();
        test_draw();
        test_timeout();
        test_match_over();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule
